ssd_scan_mux: RTL and testbench
===============================

Name: ssd_scan_mux

Overview:
Parametrised seven-segment scan multiplexer driving NUM_DIGITS common-anode digits from a packed hex value. Adds the following:
- Double-buffered loading, applied only at frame boundaries, so digits never tear mid-frame.
- Per-digit enable and decimal-point masks.
- Leading-zero suppression.
- 16-level PWM brightness.
- Anti-ghosting dead time between digits.

It sits between the game/score logic and the board SSD pins, and replaces hand-written anode/cathode scan code in top levels.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16; non-power-of-2 allowed)
DWELL_LOG2, 17, each digit is selected for 2^DWELL_LOG2 clocks (must be >= 6)
DEAD_CYCLES, 64, clocks at the start of each dwell with all anodes off (must be < 2^(DWELL_LOG2-4))

Ports:
ClkPort  in  1  system clock (100 MHz)
ResetN  in  1  asynchronous active-low reset
load  in  1  one-cycle strobe; captures digits_in/dp_in/en_in into pending buffer
digits_in  in  4*NUM_DIGITS  hex nibbles; nibble k = digit k, digit 0 = rightmost
dp_in  in  NUM_DIGITS  decimal point on per digit (1 = lit)
en_in  in  NUM_DIGITS  digit enable (0 = digit dark)
lz_en  in  1  leading-zero suppression enable (live, not buffered)
brightness  in  4  PWM level; 15 = full duty, 0 = 1/16 duty (live)
An  out  NUM_DIGITS  anodes, active-low
Cath  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
digit_idx  out  clog2(NUM_DIGITS)  index of digit currently scanned
frame_start  out  1  one-cycle pulse when digit_idx wraps to 0

Behaviour:
- Reset (async, ResetN=0):
  - prescaler, digit_idx and pending flag cleared; active digits/dp/en = 0; frame_start = 0.
  - An = all 1s; Cath = 8'hFF.
  - Display is dark until the first load has been applied.
- Prescaler: DWELL_LOG2-bit counter, increments every clock, wraps naturally.
- Dwell end (prescaler = all 1s):
  - digit_idx advances.
  - At NUM_DIGITS-1, digit_idx wraps to 0 and that cycle is a frame boundary.
- frame_start: registered; high for the one cycle after the frame boundary (coincident with digit_idx = 0, prescaler = 0).
- Load buffer:
  - load=1 copies the inputs into pending registers and sets the pending flag.
  - Repeated loads before a boundary overwrite pending; only the last load is kept.
- Frame boundary:
  - If the pending flag is set, pending is copied to active and the flag is cleared.
  - If load coincides with a boundary, the new data goes to pending with the flag set; it is applied at the next boundary. Active takes the previous pending contents if that flag was set.
- Leading-zero suppression (lz_en=1):
  - Digit k is suppressed if active nibble k = 0 and all active nibbles k+1..NUM_DIGITS-1 = 0.
  - Digit 0 is never suppressed.
  - A suppressed digit has segments a–g off; Dp still follows the dp mask.
- Anode for digit_idx is on (0) only if all of the following hold, else all anodes are 1:
  - active en[digit_idx] = 1, and
  - prescaler >= DEAD_CYCLES, and
  - prescaler[DWELL_LOG2-1 -: 4] <= brightness.
- Cath:
  - Hex decode of the active nibble: 0..9, A, b, C, d, E, F using standard patterns.
  - Dp bit = ~dp[digit_idx].
  - Forced to 8'hFF whenever all anodes are off.
- Latency: An/Cath are registered and reflect the prescaler/digit_idx state with exactly one clock of latency.
- brightness and lz_en changes take effect on the next clock; no buffering.
- No combinational path from inputs to outputs.
- Reset asserted mid-frame: outputs go to reset values immediately (async); pending data is lost.

Test Plan:
Test configuration for all scenarios: NUM_DIGITS=3, DWELL_LOG2=6, DEAD_CYCLES=2.
1. Reset release, no load -> An=3'b111, Cath=8'hFF for 500 cycles; digit_idx cycles 0,1,2; frame_start pulses every 192 cycles.
2. Load digits=12'h1A3, dp=3'b010, en=3'b111, brightness=15, lz_en=0 -> after the next frame_start:
   - digit 0: An=3'b110, Cath=8'b00001101 for prescaler 2..63 (seen at 3..64 due to latency), dark in the dead time;
   - digit 1: An=3'b101, Cath=8'b00010000 ('A' with Dp lit);
   - digit 2: An=3'b011, Cath=8'b10011111 ('1').
3. Load 12'h005 with lz_en=1 -> digits 2 and 1 show Cath=8'hFF while their anode is active; digit 0 shows '5' (8'b01001001). With lz_en=0, digits 2 and 1 show '0' (8'b00000011).
4. brightness=3 -> each anode is low only for prescaler 2..15 (14 of 64 cycles); brightness=0 -> prescaler 2..3 only.
5. Two loads (12'h111 then 12'h222) mid-frame, plus a third load (12'h333) on the boundary cycle itself -> next frame displays 222; the frame after displays 333; no frame ever mixes values.
6. ResetN pulsed low mid-dwell with digit 1 active -> An=3'b111, Cath=8'hFF in the same cycle (async); after release the display stays dark until a new load is applied.

Source files
------------

// File: rtl/ssd_scan_mux.sv
`default_nettype none
// ============================================================================
// ssd_scan_mux : frame-synchronous seven-segment scan multiplexer with PWM
// Rev 1.0
// ============================================================================
module ssd_scan_mux #(
  parameter int NUM_DIGITS  = 8,
  parameter int DWELL_LOG2  = 17,
  parameter int DEAD_CYCLES = 64
) (
  input  logic                          ClkPort,
  input  logic                          ResetN,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         en_in,
  input  logic                          lz_en,
  input  logic [3:0]                    brightness,
  output logic [NUM_DIGITS-1:0]         An,
  output logic [7:0]                    Cath,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start
);

  localparam int                    IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DWELL_LOG2-1:0] DEAD     = DWELL_LOG2'(DEAD_CYCLES);

  logic [DWELL_LOG2-1:0]   prescaler_q, prescaler_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    fs_q, fs_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              cath_q, cath_d;

  logic       dwell_end;
  logic       boundary;
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_en;
  logic       cur_sup;
  logic       all_zero;
  logic       anode_on;

  // Segment pattern {a,b,c,d,e,f,g}, active-low.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign dwell_end = &prescaler_q;
  assign boundary  = dwell_end && (idx_q == LAST_IDX);

  always_comb begin
    prescaler_d = prescaler_q + DWELL_LOG2'(1);
    idx_d       = idx_q;
    if (dwell_end) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
    fs_d = boundary;

    act_dig_d = act_dig_q;
    act_dp_d  = act_dp_q;
    act_en_d  = act_en_q;
    if (boundary && pend_flag_q) begin
      act_dig_d = pend_dig_q;
      act_dp_d  = pend_dp_q;
      act_en_d  = pend_en_q;
    end

    // A load on the boundary cycle lands in pending and waits for the next frame.
    pend_dig_d  = pend_dig_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    pend_flag_d = pend_flag_q;
    if (boundary) begin
      pend_flag_d = 1'b0;
    end
    if (load) begin
      pend_dig_d  = digits_in;
      pend_dp_d   = dp_in;
      pend_en_d   = en_in;
      pend_flag_d = 1'b1;
    end
  end

  // Scan from the top digit down so all_zero covers digit k and everything above it.
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_en   = 1'b0;
    cur_sup  = 1'b0;
    all_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero & (act_dig_q[4*k +: 4] == 4'h0);
      if (idx_q == IDX_W'(k)) begin
        cur_nib = act_dig_q[4*k +: 4];
        cur_dp  = act_dp_q[k];
        cur_en  = act_en_q[k];
        cur_sup = lz_en && all_zero && (k != 0);
      end
    end
  end

  always_comb begin
    anode_on = cur_en && (prescaler_q >= DEAD) &&
               (prescaler_q[DWELL_LOG2-1 -: 4] <= brightness);
    an_d     = '1;
    cath_d   = 8'hFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_d[k] = ~(anode_on && (idx_q == IDX_W'(k)));
    end
    if (anode_on) begin
      cath_d = {(cur_sup ? 7'h7F : seg7(cur_nib)), ~cur_dp};
    end
  end

  always_ff @(posedge ClkPort or negedge ResetN) begin
    if (!ResetN) begin
      prescaler_q <= '0;
      idx_q       <= '0;
      fs_q        <= 1'b0;
      pend_dig_q  <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      pend_flag_q <= 1'b0;
      act_dig_q   <= '0;
      act_dp_q    <= '0;
      act_en_q    <= '0;
      an_q        <= '1;
      cath_q      <= 8'hFF;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
      fs_q        <= fs_d;
      pend_dig_q  <= pend_dig_d;
      pend_dp_q   <= pend_dp_d;
      pend_en_q   <= pend_en_d;
      pend_flag_q <= pend_flag_d;
      act_dig_q   <= act_dig_d;
      act_dp_q    <= act_dp_d;
      act_en_q    <= act_en_d;
      an_q        <= an_d;
      cath_q      <= cath_d;
    end
  end

  assign An          = an_q;
  assign Cath        = cath_q;
  assign digit_idx   = idx_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_mux.sv
`default_nettype none
// ============================================================================
// tb_ssd_scan_mux : directed bench, 3 digits, 64-clock dwell, 2 dead cycles
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ssd_scan_mux;

  logic        ClkPort = 1'b0;
  logic        ResetN = 1'b0;
  logic        load = 1'b0;
  logic [11:0] digits_in = '0;
  logic [2:0]  dp_in = '0;
  logic [2:0]  en_in = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  brightness = 4'hF;
  logic [2:0]  An;
  logic [7:0]  Cath;
  logic [1:0]  digit_idx;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ClkPort = ~ClkPort;

  ssd_scan_mux #(
    .NUM_DIGITS (3),
    .DWELL_LOG2 (6),
    .DEAD_CYCLES(2)
  ) dut (
    .ClkPort    (ClkPort),
    .ResetN     (ResetN),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .lz_en      (lz_en),
    .brightness (brightness),
    .An         (An),
    .Cath       (Cath),
    .digit_idx  (digit_idx),
    .frame_start(frame_start)
  );

  task automatic tick();
    @(posedge ClkPort);
    #1;
  endtask

  task automatic do_load(input logic [11:0] d, input logic [2:0] dp, input logic [2:0] en);
    digits_in = d;
    dp_in     = dp;
    en_in     = en;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  task automatic wait_fs(input string name);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (frame_start === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: frame_start timeout, got none within 400 cycles, required a pulse", name);
    end
  endtask

  // Starts on a frame_start cycle and ends on the next one.
  task automatic check_frame(input string name, input logic [7:0] c0, input logic [7:0] c1,
                             input logic [7:0] c2, input logic [2:0] en, input logic [3:0] br,
                             output int lit0);
    logic [7:0] cexp [3];
    logic [2:0] an_exp;
    logic [7:0] cath_exp;
    int s, idx, p, exp_idx;
    bit on, exp_fs;
    cexp[0] = c0;
    cexp[1] = c1;
    cexp[2] = c2;
    lit0 = 0;
    for (int t = 1; t <= 192; t++) begin
      tick();
      s   = t - 1;
      idx = s / 64;
      p   = s % 64;
      on  = en[idx] && (p >= 2) && ((p >> 2) <= int'(br));
      an_exp   = on ? (3'b111 & ~(3'b001 << idx)) : 3'b111;
      cath_exp = on ? cexp[idx] : 8'hFF;
      if (idx == 0 && An[0] === 1'b0) lit0++;
      n_checks++;
      if ({An, Cath} !== {an_exp, cath_exp}) begin
        n_fail++;
        $display("FAIL %s t=%0d: An=%b Cath=%b, required An=%b Cath=%b",
                 name, t, An, Cath, an_exp, cath_exp);
      end
      exp_idx = (t % 192) / 64;
      exp_fs  = (t == 192);
      n_checks++;
      if ({digit_idx, frame_start} !== {exp_idx[1:0], exp_fs}) begin
        n_fail++;
        $display("FAIL %s_seq t=%0d: idx=%0d fs=%b, required idx=%0d fs=%b",
                 name, t, digit_idx, frame_start, exp_idx, exp_fs);
      end
    end
  endtask

  task automatic test_reset();
    int ei;
    bit ef;
    ResetN = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({An, Cath, digit_idx, frame_start} !== {3'b111, 8'hFF, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: An=%b Cath=%h idx=%0d fs=%b, required 111 ff 0 0",
               An, Cath, digit_idx, frame_start);
    end
    ResetN = 1'b1;
    for (int k = 1; k <= 500; k++) begin
      tick();
      ei = (k / 64) % 3;
      ef = (k % 192) == 0;
      n_checks++;
      if ({An, Cath} !== {3'b111, 8'hFF}) begin
        n_fail++;
        $display("FAIL dark_no_load k=%0d: An=%b Cath=%h, required 111 ff", k, An, Cath);
      end
      n_checks++;
      if ({digit_idx, frame_start} !== {ei[1:0], ef}) begin
        n_fail++;
        $display("FAIL scan_seq k=%0d: idx=%0d fs=%b, required idx=%0d fs=%b",
                 k, digit_idx, frame_start, ei, ef);
      end
    end
  endtask

  task automatic test_basic_display();
    int lit;
    brightness = 4'hF;
    lz_en      = 1'b0;
    wait_fs("basic_sync");
    repeat (5) tick();
    do_load(12'h1A3, 3'b010, 3'b111);
    wait_fs("basic_apply");
    check_frame("basic_1A3", 8'b00001101, 8'b00010000, 8'b10011111, 3'b111, 4'hF, lit);
    n_checks++;
    if (lit !== 62) begin
      n_fail++;
      $display("FAIL basic_lit0: lit=%0d, required 62", lit);
    end
  endtask

  task automatic test_lz_suppress();
    int lit;
    lz_en = 1'b1;
    repeat (3) tick();
    do_load(12'h005, 3'b000, 3'b111);
    wait_fs("lz_apply");
    check_frame("lz_on", 8'b01001001, 8'hFF, 8'hFF, 3'b111, 4'hF, lit);
    lz_en = 1'b0;
    check_frame("lz_off", 8'b01001001, 8'b00000011, 8'b00000011, 3'b111, 4'hF, lit);
  endtask

  task automatic test_brightness();
    int lit;
    brightness = 4'd3;
    check_frame("bright3", 8'b01001001, 8'b00000011, 8'b00000011, 3'b111, 4'd3, lit);
    n_checks++;
    if (lit !== 14) begin
      n_fail++;
      $display("FAIL bright3_lit0: lit=%0d, required 14", lit);
    end
    brightness = 4'd0;
    check_frame("bright0", 8'b01001001, 8'b00000011, 8'b00000011, 3'b111, 4'd0, lit);
    n_checks++;
    if (lit !== 2) begin
      n_fail++;
      $display("FAIL bright0_lit0: lit=%0d, required 2", lit);
    end
    brightness = 4'hF;
  endtask

  task automatic test_back_to_back();
    int lit;
    int el = 0;
    repeat (10) tick();
    el += 10;
    do_load(12'h111, 3'b000, 3'b111);
    el += 1;
    repeat (20) tick();
    el += 20;
    do_load(12'h222, 3'b000, 3'b111);
    el += 1;
    while (el < 191) begin
      tick();
      el++;
    end
    n_checks++;
    if ({digit_idx, frame_start} !== {2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_pre_boundary: idx=%0d fs=%b, required idx=2 fs=0", digit_idx, frame_start);
    end
    do_load(12'h333, 3'b000, 3'b111);
    n_checks++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_boundary_load: fs=%b, required 1", frame_start);
    end
    check_frame("b2b_222", 8'b00100101, 8'b00100101, 8'b00100101, 3'b111, 4'hF, lit);
    check_frame("b2b_333", 8'b00001101, 8'b00001101, 8'b00001101, 3'b111, 4'hF, lit);
  endtask

  task automatic test_async_reset();
    int lit;
    repeat (73) tick();
    do_load(12'h777, 3'b111, 3'b111);
    n_checks++;
    if (An !== 3'b101) begin
      n_fail++;
      $display("FAIL rst_pre_digit1: An=%b, required 101", An);
    end
    ResetN = 1'b0;
    #1;
    n_checks++;
    if ({An, Cath, digit_idx, frame_start} !== {3'b111, 8'hFF, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_async: An=%b Cath=%h idx=%0d fs=%b, required 111 ff 0 0",
               An, Cath, digit_idx, frame_start);
    end
    repeat (3) tick();
    ResetN = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      n_checks++;
      if ({An, Cath} !== {3'b111, 8'hFF}) begin
        n_fail++;
        $display("FAIL rst_dark k=%0d: An=%b Cath=%h, required 111 ff", k, An, Cath);
      end
    end
    do_load(12'h1A3, 3'b010, 3'b111);
    wait_fs("rst_reload_apply");
    check_frame("rst_reload", 8'b00001101, 8'b00010000, 8'b10011111, 3'b111, 4'hF, lit);
  endtask

  initial begin
    test_reset();
    test_basic_display();
    test_lz_suppress();
    test_brightness();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
